uart_tx: RTL

8N1 UART transmitter that serialises one byte per start request onto the board TX pin. It sits directly downstream of the byte-to-ASCII message sequencer. It accepts that block's one-cycle-per-state `start` strobe and its registered `data_out` byte. It returns the `tx_done` pulse the sequencer waits on before issuing the next character.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_baud_cnt.sv | 35 +++
 rtl/uart_tx.sv | 105 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART transmitter: state encoding,
// default bit rate and frame constants.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

   // 50 MHz system clock / 115200 baud
   localparam int CLKS_PER_BIT_DEFAULT = 434;

   localparam int   DATA_BITS   = 8;
   localparam int   BIT_IDX_W   = $clog2(DATA_BITS);
   localparam logic STOP_LEVEL  = 1'b1;
   localparam logic IDLE_LEVEL  = 1'b1;
   localparam logic START_LEVEL = 1'b0;

   // Counter width for a modulo-n counter; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Modulo-CLKS_PER_BIT baud counter. Counts 0..CLKS_PER_BIT-1 and wraps;
// a synchronous clear holds it at zero. tick marks the terminal count.
module uart_baud_cnt
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
   input  logic clk,
   input  logic n_rst,
   input  logic clear,
   output logic tick
);

   localparam int               CNT_W = cnt_width(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] TERM  = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_r;

   // Free-running modulo counter, cleared while the transmitter is idle.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cnt_r <= '0;
      end else if (clear) begin
         cnt_r <= '0;
      end else if (cnt_r == TERM) begin
         cnt_r <= '0;
      end else begin
         cnt_r <= cnt_r + CNT_W'(1);
      end
   end

   // Terminal-count decode of the registered count.
   assign tick = (cnt_r == TERM);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: one start bit, eight data bits LSB first, one
// stop bit. The byte is captured one cycle after start is accepted so
// that an upstream registered data byte lines up with its strobe.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       start,
   input  logic [7:0] data_in,
   output logic       tx,
   output logic       tx_done,
   output logic       busy
);

   localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_BITS - 1);

   uart_state_t              state_r;
   logic [DATA_BITS-1:0]     shift_r;
   logic [BIT_IDX_W-1:0]     bit_idx_r;
   logic                     load_r;
   logic                     baud_clear_s;
   logic                     baud_tick_s;

   // The bit timer only runs while a frame is in flight.
   assign baud_clear_s = (state_r == IDLE);

   uart_baud_cnt #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud_cnt (
      .clk   (clk),
      .n_rst (n_rst),
      .clear (baud_clear_s),
      .tick  (baud_tick_s)
   );

   // Frame sequencer with registered line, done and busy outputs.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_r   <= IDLE;
         shift_r   <= '0;
         bit_idx_r <= '0;
         load_r    <= 1'b0;
         tx        <= IDLE_LEVEL;
         tx_done   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start) begin
                  state_r <= START;
                  tx      <= START_LEVEL;
                  busy    <= 1'b1;
                  load_r  <= 1'b1;
               end else begin
                  tx      <= IDLE_LEVEL;
                  busy    <= 1'b0;
               end
            end
            START: begin
               // First edge in START: data_in is valid one cycle after start.
               if (load_r) begin
                  shift_r <= data_in;
                  load_r  <= 1'b0;
               end
               if (baud_tick_s) begin
                  state_r   <= DATA;
                  tx        <= shift_r[0];
                  bit_idx_r <= '0;
               end
            end
            DATA: begin
               if (baud_tick_s) begin
                  if (bit_idx_r == LAST_BIT) begin
                     state_r <= STOP;
                     tx      <= STOP_LEVEL;
                  end else begin
                     shift_r   <= shift_r >> 1;
                     tx        <= shift_r[1];
                     bit_idx_r <= bit_idx_r + BIT_IDX_W'(1);
                  end
               end
            end
            STOP: begin
               if (baud_tick_s) begin
                  state_r <= IDLE;
                  tx      <= IDLE_LEVEL;
                  tx_done <= 1'b1;
                  busy    <= 1'b0;
               end
            end
            default: begin
               state_r <= IDLE;
               tx      <= IDLE_LEVEL;
               busy    <= 1'b0;
               load_r  <= 1'b0;
            end
         endcase
      end
   end

endmodule
